dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single data-memory port between the pipelined core's load/store unit (requester 0) and the external program/debug loader (requester 1). It sits between `riscvpipelined`, the loader and `dmem`. Each cycle it grants at most one access, round-robin by default with an optional lock for loader bursts. It routes the one-cycle-latency read data back to the requester that issued the read.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arbiter_rr_arb2.sv | 31 +++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared types and constants for the data-memory arbiter.
//   owner_t   : which requester a grant or a returning read belongs to
//   NUM_REQ   : number of requesters sharing the memory port
//   grant_owner() : converts a one-hot grant vector to an owner_t
package dmem_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    OWN_CORE   = 1'b0,
    OWN_LOADER = 1'b1
  } owner_t;

  // Only meaningful for a non-zero one-hot grant; an empty grant maps to
  // OWN_CORE, and callers qualify it with their own "any grant" term.
  function automatic owner_t grant_owner(input logic [NUM_REQ-1:0] gnt);
    return gnt[1] ? OWN_LOADER : OWN_CORE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin pick with a lock override.
//   req[1:0]  in  : request vector (bit 0 = core, bit 1 = loader)
//   last      in  : requester granted most recently
//   lock_hold in  : loader owns the port this cycle regardless of req[0]
//   gnt[1:0]  out : one-hot grant, all zero when nothing requests
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  owner_t             last,
  input  logic               lock_hold,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (lock_hold) begin
      gnt = 2'b10;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // Contested: the requester that did not win last time goes now.
        2'b11:   gnt = (last == OWN_LOADER) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-memory port between the core load/store unit
//   (requester 0) and the program/debug loader (requester 1). At most one
//   access is granted per cycle, combinationally in the request cycle.
//   Read data returns one cycle later to the requester that issued it.
//
//   clk, reset                 : clock, synchronous active-high reset
//   m0_req/we/addr/wdata       : core request fields (held until gnt)
//   m0_gnt, m0_rvalid, m0_rdata: core grant and read return
//   m1_*                       : loader equivalents of the m0_* ports
//   m1_lock                    : loader keeps ownership while asserted with m1_req
//   mem_we/addr/wdata          : memory port driven by the granted requester
//   mem_rdata                  : memory read data, one cycle after the address
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  owner_t             last_q;
  owner_t             rd_owner_q;
  logic               locked_q;
  logic               rd_pend_q;

  logic [NUM_REQ-1:0] req_v;
  logic [NUM_REQ-1:0] gnt_v;
  logic               lock_hold;
  logic               any_gnt;
  owner_t             gnt_own;
  logic               rd_ret;

  // Masking requests during reset forces every grant, and therefore
  // mem_we, low without a second gating stage on the outputs.
  assign req_v = reset ? '0 : {m1_req, m0_req};

  // Dropping either m1_req or m1_lock releases ownership in that same cycle,
  // so the core can win a contest immediately.
  assign lock_hold = ~reset & locked_q & m1_req & m1_lock;

  rr_arb2 u_rr_arb2 (
    .req       (req_v),
    .last      (last_q),
    .lock_hold (lock_hold),
    .gnt       (gnt_v)
  );

  assign any_gnt = |gnt_v;
  assign gnt_own = grant_owner(gnt_v);
  assign m0_gnt  = gnt_v[0];
  assign m1_gnt  = gnt_v[1];

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_v[1]) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else if (gnt_v[0]) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end
  end

  // A read in flight when reset arrives is dropped, not delivered.
  assign rd_ret    = rd_pend_q & ~reset;
  assign m0_rvalid = rd_ret & (rd_owner_q == OWN_CORE);
  assign m1_rvalid = rd_ret & (rd_owner_q == OWN_LOADER);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= OWN_LOADER;
      locked_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWN_CORE;
    end else begin
      // Grants made under the lock leave last at the loader value recorded
      // by the grant that took the lock, so the core wins right after unlock.
      if (any_gnt && !lock_hold) begin
        last_q <= gnt_own;
      end
      locked_q  <= gnt_v[1] & m1_lock;
      rd_pend_q <= any_gnt & ~mem_we;
      if (any_gnt && !mem_we) begin
        rd_owner_q <= gnt_own;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m0_gnt, m0_rvalid;
  logic        m1_req, m1_we, m1_lock;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_gnt, m1_rvalid;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_lock   (m1_lock),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after the inputs change.
  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h4; m0_wdata = 32'h1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8; m1_wdata = 32'h2; m1_lock = 1'b1;
    mem_rdata = 32'h0;

    // Reset: requests present but nothing may be granted.
    tick(); settle();
    chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    tick();
    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0; m0_we = 1'b0; m1_we = 1'b0;

    // Single core read of 0x40, data returns next cycle.
    m0_req = 1'b1; m0_addr = 32'h40;
    settle();
    chk("rd_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("rd_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("rd_mem_addr", mem_addr, 32'h40);
    chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    m0_req = 1'b0; mem_rdata = 32'hDEADBEEF;
    settle();
    chk("rd_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("rd_m1_rdata", m1_rdata, 32'd0);

    // One reset cycle restores last=loader so the next contest starts with the core.
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Both read continuously: grants 0,1,0,1; each read returns to its owner.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h80;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h90;
    for (int c = 0; c < 4; c++) begin
      mem_rdata = 32'hA0000000 + c;
      settle();
      chk("rr_m0_gnt", {31'd0, m0_gnt}, (c % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_m1_gnt", {31'd0, m1_gnt}, (c % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_mem_addr", mem_addr, (c % 2 == 0) ? 32'h80 : 32'h90);
      if (c > 0) begin
        chk("rr_m0_rvalid", {31'd0, m0_rvalid}, ((c - 1) % 2 == 0) ? 32'd1 : 32'd0);
        chk("rr_m1_rvalid", {31'd0, m1_rvalid}, ((c - 1) % 2 == 1) ? 32'd1 : 32'd0);
        chk("rr_m0_rdata", m0_rdata, ((c - 1) % 2 == 0) ? 32'hA0000000 + c : 32'd0);
        chk("rr_m1_rdata", m1_rdata, ((c - 1) % 2 == 1) ? 32'hA0000000 + c : 32'd0);
      end
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0; mem_rdata = 32'h5555AAAA;
    settle();
    chk("rr_tail_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
    chk("rr_tail_m1_rdata", m1_rdata, 32'h5555AAAA);
    chk("rr_tail_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    // last = loader now.

    // Locked loader burst against a continuously requesting core.
    tick();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h200;
    m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1; m1_addr = 32'h100; m1_wdata = 32'hB0;
    settle();
    // Lock has no effect before the loader is granted; last=loader so core wins.
    chk("lk_pre_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("lk_pre_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    tick();
    mem_rdata = 32'hC0FFEE00;
    settle();
    chk("lk_core_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("lk_core_rdata", m0_rdata, 32'hC0FFEE00);
    for (int b = 0; b < 4; b++) begin
      m1_addr = 32'h100 + 4 * b; m1_wdata = 32'hB0 + b;
      settle();
      chk("lk_m1_gnt", {31'd0, m1_gnt}, 32'd1);
      chk("lk_m0_gnt", {31'd0, m0_gnt}, 32'd0);
      chk("lk_mem_we", {31'd0, mem_we}, 32'd1);
      chk("lk_mem_addr", mem_addr, 32'h100 + 4 * b);
      chk("lk_mem_wdata", mem_wdata, 32'hB0 + b);
      tick();
    end
    // Lock dropped, loader still requests: core wins the contest.
    m1_lock = 1'b0; m1_addr = 32'h110;
    settle();
    chk("unlk_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("unlk_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("unlk_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    tick();
    settle();
    chk("unlk2_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    chk("unlk2_mem_addr", mem_addr, 32'h110);
    tick();

    // Core store.
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h12345678;
    settle();
    chk("st_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("st_mem_we", {31'd0, mem_we}, 32'd1);
    chk("st_mem_addr", mem_addr, 32'h20);
    chk("st_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    m0_req = 1'b0; m0_we = 1'b0;
    settle();
    chk("st_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("st_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);

    // Locked loader read, then reset in the following cycle.
    m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b1; m1_addr = 32'h300;
    settle();
    chk("rl_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    tick();
    reset = 1'b1; m0_req = 1'b1; m0_addr = 32'h44; mem_rdata = 32'h77777777;
    settle();
    chk("rl_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("rl_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rl_m1_rdata", m1_rdata, 32'd0);
    chk("rl_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    tick();
    reset = 1'b0;
    settle();
    // Lock cleared and last=loader: core wins although m1_lock is still high.
    chk("post_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("post_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("post_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    tick();
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    // last = core now.

    // Idle for three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk("idle_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
    end
    // last stayed at core, so the loader wins the next contest.
    m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b0;
    settle();
    chk("idle_after_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    chk("idle_after_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    tick();
    m0_req = 1'b0; m1_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
